// File: rtl/alu_seq_pkg.sv
// Shared op codes, func bit indices and FSM encoding for the sequential ALU.
// The optional divider is controlled by ALU_SEQ_DIV_EN.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_PAS1 = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_PAS2 = 3'b011;
    localparam logic [2:0] OP_MLT  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    localparam int FUNC_HI_BIT  = 0;
    localparam int FUNC_DIV_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// Divider step exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_run,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi_next,
    output logic [WIDTH-1:0] o_lo_next
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    // {r_hi, r_lo} is the product shifting right; r_lo starts as the multiplier.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_div_sub;
    logic             w_ge;

    // r_hi is the partial remainder; dividend bits leave r_lo as quotient bits enter.
    // A zero divisor always subtracts nothing, yielding all-ones quotient and remainder = dividend.
    assign w_shift   = {r_hi, r_lo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_opnd});
    assign w_div_sub = w_shift[WIDTH-1:0] - r_opnd;
    assign w_div_hi  = w_ge ? w_div_sub : w_shift[WIDTH-1:0];
    assign w_div_lo  = {r_lo[WIDTH-2:0], w_ge};
`else
    assign w_div_hi  = r_hi;
    assign w_div_lo  = r_lo;
`endif

    assign o_hi_next = r_mode ? w_div_hi : w_mul_hi;
    assign o_lo_next = r_mode ? w_div_lo : w_mul_lo;
    assign o_last    = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (i_load) begin
            r_hi   <= '0;
            r_lo   <= i_a;
            r_opnd <= i_b;
            r_cnt  <= '0;
            r_mode <= i_mode;
        end else if (i_run) begin
            r_hi   <= o_hi_next;
            r_lo   <= o_lo_next;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake and registered outputs.
// Define ALU_SEQ_DIV_EN to make MLT with func[1]=1 perform a restoring divide.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       opr,
    input  logic [1:0]       func,
    input  logic [WIDTH-1:0] var1,
    input  logic [WIDTH-1:0] var2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             sign,
    output logic             zero,
    output logic             div_by_zero
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_sign;
    logic             r_zero;
    logic             r_div_by_zero;
    logic             r_func_hi;

    logic             w_accept;
    logic             w_multi;
    logic             w_last;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic [WIDTH-1:0] w_final_res;
    logic [WIDTH-1:0] w_single_res;
    logic             w_single_sign;

    assign w_accept = (r_state == ST_IDLE) && start;

`ifdef ALU_SEQ_DIV_EN
    logic r_func_div;
    logic r_b_zero;
    assign w_multi     = (opr == OP_MLT);
    assign w_final_res = (r_func_div || !r_func_hi) ? w_lo_next : w_hi_next;
`else
    assign w_multi     = (opr == OP_MLT) && !func[FUNC_DIV_BIT];
    assign w_final_res = r_func_hi ? w_hi_next : w_lo_next;
`endif

    alu_seq_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_load    (w_accept),
        .i_run     (r_state == ST_ITER),
        .i_mode    (func[FUNC_DIV_BIT]),
        .i_a       (var1),
        .i_b       (var2),
        .o_last    (w_last),
        .o_hi_next (w_hi_next),
        .o_lo_next (w_lo_next)
    );

    // Single-cycle ops; MLT lands here only as the disabled divide, which yields zeros.
    always_comb begin
        w_single_res  = '0;
        w_single_sign = 1'b0;
        case (opr)
            OP_ADD:  {w_single_sign, w_single_res} = {1'b0, var1} + {1'b0, var2};
            OP_SUB:  {w_single_sign, w_single_res} = {1'b0, var1} - {1'b0, var2};
            OP_PAS1: w_single_res = var1;
            OP_PAS2: w_single_res = var2;
            OP_AND:  w_single_res = var1 & var2;
            OP_OR:   w_single_res = var1 | var2;
            OP_XOR:  w_single_res = var1 ^ var2;
            default: w_single_res = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = w_multi ? ST_ITER : ST_DONE;
            ST_ITER: if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_result      <= '0;
            r_result_hi   <= '0;
            r_sign        <= 1'b0;
            r_zero        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_func_hi     <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            r_func_div    <= 1'b0;
            r_b_zero      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_div_by_zero <= 1'b0;
                r_func_hi     <= func[FUNC_HI_BIT];
`ifdef ALU_SEQ_DIV_EN
                r_func_div    <= func[FUNC_DIV_BIT];
                r_b_zero      <= (var2 == '0);
`endif
                if (!w_multi) begin
                    r_result    <= w_single_res;
                    r_result_hi <= '0;
                    r_sign      <= w_single_sign;
                    r_zero      <= (w_single_res == '0);
                end
            end else if (r_state == ST_ITER && w_last) begin
                // Final step's values are taken straight from the datapath.
                r_result    <= w_final_res;
                r_result_hi <= w_hi_next;
                r_sign      <= 1'b0;
                r_zero      <= (w_final_res == '0);
`ifdef ALU_SEQ_DIV_EN
                r_div_by_zero <= r_func_div && r_b_zero;
`endif
            end
        end
    end

    assign busy        = (r_state == ST_ITER);
    assign done        = (r_state == ST_DONE);
    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign sign        = r_sign;
    assign zero        = r_zero;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16); expectations adapt to ALU_SEQ_DIV_EN.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   opr = '0;
    logic [1:0]   func = '0;
    logic [W-1:0] var1 = '0;
    logic [W-1:0] var2 = '0;
    logic         busy, done, sign, zero, div_by_zero;
    logic [W-1:0] result, result_hi;

    alu_seq #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .opr         (opr),
        .func        (func),
        .var1        (var1),
        .var2        (var2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_hi   (result_hi),
        .sign        (sign),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         sgn;
        logic         zr;
        logic         dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [1:0] fn,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W:0]   t;
        logic [2*W-1:0] p;
        e.res = '0; e.hi = '0; e.sgn = 1'b0; e.dbz = 1'b0;
        case (op)
            OP_ADD:  begin t = {1'b0, a} + {1'b0, b}; e.res = t[W-1:0]; e.sgn = t[W]; end
            OP_SUB:  begin t = {1'b0, a} - {1'b0, b}; e.res = t[W-1:0]; e.sgn = t[W]; end
            OP_PAS1: e.res = a;
            OP_PAS2: e.res = b;
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_XOR:  e.res = a ^ b;
            default: begin
                if (!fn[1]) begin
                    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    e.hi  = p[2*W-1:W];
                    e.res = fn[0] ? p[2*W-1:W] : p[W-1:0];
                end else begin
`ifdef ALU_SEQ_DIV_EN
                    if (b == '0) begin
                        e.res = '1; e.hi = a; e.dbz = 1'b1;
                    end else begin
                        e.res = a / b; e.hi = a % b;
                    end
`endif
                end
            end
        endcase
        e.zr = (e.res == '0);
        return e;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [1:0] fn);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MLT) ? W + 1 : 1;
`else
        return (op == OP_MLT && !fn[1]) ? W + 1 : 1;
`endif
    endfunction

    // Scoreboard consumer: one pop per done pulse.
    always @(negedge clock) begin
        if (done) begin
            exp_t e;
            check("busy_with_done", busy, 1'b0);
            check("sb_nonempty_at_done", (sb_q.size() != 0), 1'b1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("result_hi", result_hi, e.hi);
                check("sign", sign, e.sgn);
                check("zero", zero, e.zr);
                check("div_by_zero", div_by_zero, e.dbz);
            end
        end
    end

    task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] fn,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        int n, nb, lat;
        bit seen;
        sb_q.push_back(model(op, fn, a, b));
        lat = exp_lat(op, fn);
        @(negedge clock);
        start = 1'b1; opr = op; func = fn; var1 = a; var2 = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        opr  = 3'($urandom_range(0, 7));
        func = 2'($urandom_range(0, 3));
        var1 = W'($urandom);
        var2 = W'($urandom);
        n = 0; nb = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clock);
            n++;
            if (busy) nb++;
            if (done) seen = 1'b1;
            if (poke && n == 3) begin start = 1'b1; opr = OP_ADD; end
            if (poke && n == 6) start = 1'b0;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " busy_cycles"}, nb, lat - 1);
        $display("op %s opr=%0d func=%0d a=0x%0h b=0x%0h latency=%0d", tag, op, fn, a, b, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        logic [2:0]   rop;
        logic [1:0]   rfn;
        logic [W-1:0] ra, rb;

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst result", result, '0);
        check("rst result_hi", result_hi, '0);
        check("rst sign", sign, 1'b0);
        check("rst zero", zero, 1'b0);
        check("rst div_by_zero", div_by_zero, 1'b0);

        run_op("add_wrap", OP_ADD, 2'b00, 16'hFFFF, 16'h0001, 1'b0);
        run_op("mul_ffff_lo", OP_MLT, 2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
        run_op("mul_ffff_hi", OP_MLT, 2'b01, 16'hFFFF, 16'hFFFF, 1'b0);
        run_op("div_1000_7", OP_MLT, 2'b10, 16'd1000, 16'd7, 1'b0);
        run_op("div_5_0", OP_MLT, 2'b10, 16'd5, 16'd0, 1'b0);
        run_op("dbz_clear", OP_PAS1, 2'b00, 16'h00A5, 16'h0000, 1'b0);
        run_op("mul_poke", OP_MLT, 2'b00, 16'h1234, 16'h0101, 1'b1);

        // start held high: SUB accepted on every other edge
        repeat (4) sb_q.push_back(model(OP_SUB, 2'b00, 16'd3, 16'd5));
        @(negedge clock);
        start = 1'b1; opr = OP_SUB; func = 2'b00; var1 = 16'd3; var2 = 16'd5;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            check($sformatf("hold_start done c%0d", i), done, ((i % 2) == 1));
            if (i == 7) start = 1'b0;
        end
        $display("op hold_start sub 3-5 x4");

        // reset pulse during iteration 8 of a multiply
        @(negedge clock);
        start = 1'b1; opr = OP_MLT; func = 2'b00; var1 = 16'h1234; var2 = 16'h5678;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (8) @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort result", result, '0);
        check("abort result_hi", result_hi, '0);
        check("abort sign", sign, 1'b0);
        check("abort zero", zero, 1'b0);
        check("abort div_by_zero", div_by_zero, 1'b0);
        n_done = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("abort no_done", n_done, 0);
        $display("op abort_mul reset at iteration 8");
        run_op("after_reset_mul", OP_MLT, 2'b00, 16'h00FF, 16'h0102, 1'b0);

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            rfn = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            run_op($sformatf("rand%0d", k), rop, rfn, ra, rb, (k % 5) == 0);
        end

        repeat (3) @(negedge clock);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
